// File: rtl/openfpga_cfg_pkg.sv
// Shared definitions for the configuration chain loader: FSM encoding and
// beat-counter sizing.
package openfpga_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cfg_state_e;

  // The counter must be able to hold LENGTH itself, not just LENGTH-1.
  function automatic int cnt_width(input int length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/openfpga_cfg_shift.sv
// One configuration chain: serial-in shift register with parallel outputs
// and a tail bit for readback of the previous contents.
module openfpga_cfg_shift #(
  parameter int unsigned LENGTH = 16,
  parameter logic        INIT   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sin_i,
  output logic              sout_o,
  output logic [LENGTH-1:0] q_o
);

  logic [LENGTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= {LENGTH{INIT}};
    end else if (en_i) begin
      q_q <= {q_q[LENGTH-2:0], sin_i};
    end
  end

  assign q_o    = q_q;
  assign sout_o = q_q[LENGTH-1];

endmodule

// File: rtl/openfpga_cfg_chain.sv
// Loads CHANNELS configuration chains in lockstep from a valid/ready beat
// stream and reports completion with a one-cycle done pulse.
module openfpga_cfg_chain
  import openfpga_cfg_pkg::*;
#(
  parameter int unsigned LENGTH   = 16,
  parameter int unsigned CHANNELS = 1,
  parameter logic        INIT     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [CHANNELS-1:0]          din,
  output logic [CHANNELS-1:0]          dout,
  output logic [CHANNELS*LENGTH-1:0]   q,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_valid
);

  localparam int CW = cnt_width(LENGTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LENGTH - 1);

  cfg_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          cfg_valid_q;
  logic          shift_en;

  // Handshake: a beat transfers on an edge where din_valid && din_ready;
  // din_ready is a pure decode of the state register. An abort in SHIFT
  // wins over an offered beat, so that edge never shifts.
  assign din_ready = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign cfg_valid = cfg_valid_q;
  assign shift_en  = din_ready & din_valid & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SHIFT;
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (din_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q     <= ST_DONE;
              cfg_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chain
    openfpga_cfg_shift #(
      .LENGTH (LENGTH),
      .INIT   (INIT)
    ) u_chain (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (shift_en),
      .sin_i  (din[c]),
      .sout_o (dout[c]),
      .q_o    (q[c*LENGTH +: LENGTH])
    );
  end

endmodule

// File: tb/tb_openfpga_cfg_chain.sv
// Bench for openfpga_cfg_chain (LENGTH=4, CHANNELS=2): directed scenarios plus
// random traffic against a transaction-level reference model.
module tb_openfpga_cfg_chain;

  localparam int   L      = 4;
  localparam int   C      = 2;
  localparam logic INIT_B = 1'b0;
  localparam int   W      = C * L;

  logic         clk = 1'b0;
  logic         rst, start, abort, din_valid;
  logic         din_ready;
  logic [C-1:0] din, dout;
  logic [W-1:0] q;
  logic         busy, done, cfg_valid;

  int errors = 0;
  int checks = 0;

  // reference model: chain contents as words, bit 0 = newest beat
  logic [L-1:0] m_chain [C];
  bit           m_loading, m_done, m_valid;
  int           m_beats;

  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  openfpga_cfg_chain #(.LENGTH(L), .CHANNELS(C), .INIT(INIT_B)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .dout      (dout),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .cfg_valid (cfg_valid)
  );

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    for (int c = 0; c < C; c++) w[c*L +: L] = m_chain[c];
    return w;
  endfunction

  function automatic logic [C-1:0] model_dout();
    logic [C-1:0] d;
    for (int c = 0; c < C; c++) d[c] = m_chain[c][L-1];
    return d;
  endfunction

  // driver: apply one clock edge, advancing the model from the pre-edge state
  task automatic apply(input logic r, input logic s, input logic a,
                       input logic v, input logic [C-1:0] d, output bit acc);
    rst = r; start = s; abort = a; din_valid = v; din = d;
    acc = 0;
    if (r) begin
      for (int c = 0; c < C; c++) m_chain[c] = {L{INIT_B}};
      m_loading = 0; m_done = 0; m_valid = 0; m_beats = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_loading) begin
      if (s) begin m_loading = 1; m_beats = 0; m_valid = 0; end
    end else if (a) begin
      m_loading = 0;
    end else if (v) begin
      acc = 1;
      for (int c = 0; c < C; c++) m_chain[c] = (m_chain[c] << 1) | L'(d[c]);
      m_beats++;
      if (m_beats == L) begin m_loading = 0; m_done = 1; m_valid = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_edge();
    bit acc;
    apply(0, 0, 0, 0, '0, acc);
  endtask

  task automatic test_reset();
    bit acc;
    apply(1, 0, 0, 0, '0, acc);
    apply(1, 1, 0, 1, '1, acc);
    checks++; if (q !== {W{INIT_B}}) begin errors++; $display("FAIL reset_q: got %h want %h", q, {W{INIT_B}}); end
    checks++; if (dout !== {C{INIT_B}}) begin errors++; $display("FAIL reset_dout: got %b want %b", dout, {C{INIT_B}}); end
    checks++; if (done !== 1'b0 || cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b cfg_valid=%b want 0 0", done, cfg_valid); end
    checks++; if (busy !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b din_ready=%b want 0 0", busy, din_ready); end
    idle_edge();
  endtask

  task automatic test_basic_load();
    logic [C-1:0] beats [4];
    bit acc;
    int edges;
    beats[0] = 2'b10; beats[1] = 2'b01; beats[2] = 2'b11; beats[3] = 2'b00;
    apply(0, 1, 0, 1, '0, acc);
    edges = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL basic_ready beat %0d: got %b want 1", i, din_ready); end
      apply(0, 0, 0, 1, beats[i], acc);
      edges++;
      if (i < 3) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done beat %0d: got %b want 0", i, done); end
      end
    end
    checks++; if (done !== 1'b1 || edges != L) begin errors++; $display("FAIL basic_done: got done=%b after %0d beats want 1 after %0d", done, edges, L); end
    checks++; if (q !== model_word()) begin errors++; $display("FAIL basic_q: got %h want %h", q, model_word()); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL basic_cfg_valid: got %b want 1", cfg_valid); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL basic_no_accept_in_done: got %b want 0", din_ready); end
    idle_edge();
    checks++; if (done !== 1'b0 || cfg_valid !== 1'b1) begin errors++; $display("FAIL basic_after: done=%b cfg_valid=%b want 0 1", done, cfg_valid); end
  endtask

  // readback of prior contents through dout, scored against an expected queue
  task automatic test_readback();
    bit acc;
    logic [W-1:0] want;
    for (int i = 0; i < L; i++) exp_q.push_back(W'(model_dout() == model_dout() ? m_chain[0][L-1-i] : 1'b0));
    apply(0, 1, 0, 0, '0, acc);
    for (int i = 0; i < L; i++) begin
      want = exp_q.pop_front();
      checks++; if (W'(dout[0]) !== want) begin errors++; $display("FAIL readback beat %0d: got %b want %b", i, dout[0], want[0]); end
      apply(0, 0, 0, 1, '1, acc);
    end
    checks++; if (q !== {W{1'b1}}) begin errors++; $display("FAIL readback_q: got %h want %h", q, {W{1'b1}}); end
    idle_edge();
  endtask

  task automatic test_valid_toggle();
    bit acc;
    int accepted, edges;
    apply(0, 1, 0, 0, '0, acc);
    accepted = 0; edges = 0;
    while (accepted < L && edges < 20) begin
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL toggle_ready edge %0d: got %b want 1", edges, din_ready); end
      apply(0, 0, 0, (edges % 2) == 0, C'($urandom), acc);
      if (acc) accepted++;
      edges++;
    end
    checks++; if (edges != 2*L-1 || done !== 1'b1) begin errors++; $display("FAIL toggle_done: got done=%b after %0d edges want 1 after %0d", done, edges, 2*L-1); end
    checks++; if (q !== model_word()) begin errors++; $display("FAIL toggle_q: got %h want %h", q, model_word()); end
    idle_edge();
  endtask

  task automatic test_abort();
    bit acc;
    logic [W-1:0] held;
    apply(0, 1, 0, 0, '0, acc);
    apply(0, 0, 0, 1, C'($urandom), acc);
    apply(0, 0, 0, 1, C'($urandom), acc);
    held = model_word();
    apply(0, 1, 1, 1, C'($urandom), acc);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cfg_valid !== 1'b0) begin errors++; $display("FAIL abort_flags: busy=%b done=%b cfg_valid=%b want 0 0 0", busy, done, cfg_valid); end
    checks++; if (q !== held) begin errors++; $display("FAIL abort_q: got %h want %h", q, held); end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 1, C'($urandom), acc);
      checks++; if (done !== 1'b0 || q !== held) begin errors++; $display("FAIL abort_quiet: done=%b q=%h want 0 %h", done, q, held); end
    end
    apply(0, 1, 0, 0, '0, acc);
    for (int i = 0; i < L; i++) apply(0, 0, 0, 1, C'($urandom), acc);
    checks++; if (done !== 1'b1 || cfg_valid !== 1'b1 || q !== model_word()) begin errors++; $display("FAIL abort_reload: done=%b cfg_valid=%b q=%h want 1 1 %h", done, cfg_valid, q, model_word()); end
    idle_edge();
  endtask

  task automatic test_reset_mid_load();
    bit acc;
    apply(0, 1, 0, 0, '0, acc);
    apply(0, 0, 0, 1, '1, acc);
    apply(0, 0, 0, 1, '1, acc);
    apply(1, 0, 0, 1, '1, acc);
    checks++; if (q !== {W{INIT_B}} || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid: q=%h busy=%b done=%b want %h 0 0", q, busy, done, {W{INIT_B}}); end
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 1, '1, acc);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b want 0", done); end
    end
    apply(1, 1, 0, 1, '1, acc);
    checks++; if (busy !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL rst_with_start: busy=%b din_ready=%b want 0 0", busy, din_ready); end
    idle_edge();
  endtask

  task automatic test_start_in_shift();
    bit acc;
    int accepted;
    apply(0, 1, 0, 0, '0, acc);
    accepted = 0;
    for (int i = 0; i < L; i++) begin
      apply(0, (i == 1 || i == 2), 0, 1, C'($urandom), acc);
      if (acc) accepted++;
      if (i < L-1) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_early_done beat %0d: got %b want 0", i, done); end
      end
    end
    checks++; if (done !== 1'b1 || accepted != L) begin errors++; $display("FAIL restart_done: got done=%b after %0d beats want 1 after %0d", done, accepted, L); end
    checks++; if (q !== model_word()) begin errors++; $display("FAIL restart_q: got %h want %h", q, model_word()); end
    idle_edge();
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 400; i++) begin
      checks++; if (din_ready !== m_loading || dout !== model_dout()) begin errors++; $display("FAIL rand_pre cyc %0d: din_ready=%b dout=%b want %b %b", i, din_ready, dout, m_loading, model_dout()); end
      apply($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 70, C'($urandom), acc);
      checks++; if (q !== model_word()) begin errors++; $display("FAIL rand_q cyc %0d: got %h want %h", i, q, model_word()); end
      checks++; if (done !== m_done || cfg_valid !== m_valid || busy !== m_loading) begin errors++; $display("FAIL rand_flags cyc %0d: done=%b cfg_valid=%b busy=%b want %b %b %b", i, done, cfg_valid, busy, m_done, m_valid, m_loading); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = '0;
    test_reset();
    test_basic_load();
    test_readback();
    test_valid_toggle();
    test_abort();
    test_reset_mid_load();
    test_start_in_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
